seg_scan_arbiter: RTL and testbench
===================================

SEG_SCAN_ARBITER -- requirements
Module: seg_scan_arbiter

Interface
REQ-001 The module SHALL have parameter HOLD_FRAMES, default 250: number of complete scan frames requester B keeps the display after its last request.
REQ-002 The module SHALL have parameter LZ_BLANK, default 1: 1 = leading-zero blanking on, 0 = off.
REQ-003 Clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 Resetn  input  1  reset; synchronous and active-low.
REQ-005 ScanTick  input  1  one-cycle pulse from the clock divider; advances the digit scan.
REQ-006 ReqA  input  1  level request from the score source (low priority, background).
REQ-007 DataA  input  16  score as four BCD nibbles; [3:0] is the rightmost digit.
REQ-008 ReqB  input  1  one-cycle pulse request from the keyboard-echo source (high priority).
REQ-009 DataB  input  16  key-echo value as four BCD nibbles, sampled in the ReqB cycle.
REQ-010 GrantA  output  1  high while the display shows A data.
REQ-011 GrantB  output  1  high while the display shows B data.
REQ-012 DigitEn_n  output  4  active-low digit enables; bit i drives digit i.
REQ-013 Seg_n  output  7  active-low segments {g,f,e,d,c,b,a}.

Function
REQ-014 A 2-bit digit index SHALL increment on each ScanTick and wrap 3 -> 0; a frame boundary is a ScanTick with the index at 3.
REQ-015 The FSM SHALL have states IDLE, SHOW_A and SHOW_B, and SHALL change state only at frame boundaries.
REQ-016 A ReqB pulse SHALL set a pending flag and capture DataB into a B shadow register; a later ReqB before the boundary SHALL overwrite the shadow.
REQ-017 At a boundary with pending set, the FSM SHALL enter SHOW_B from any state, load the hold counter with HOLD_FRAMES-1, clear pending, and copy the shadow to the display register.
REQ-018 In SHOW_B with no pending, each boundary SHALL decrement the hold counter; at a boundary with the counter at 0, the FSM SHALL go to SHOW_A if ReqA=1, else to IDLE.
REQ-019 In IDLE, a boundary with ReqA=1 SHALL enter SHOW_A; in SHOW_A, a boundary with ReqA=0 SHALL enter IDLE.
REQ-020 In SHOW_A, DataA SHALL be copied to the display register at every boundary, so there is no mid-frame tearing.
REQ-021 A pending ReqB and hold expiry at the same boundary SHALL resolve to SHOW_B with the counter reloaded.
REQ-022 A ReqB arriving in the same cycle as a boundary SHALL be counted as pending for that boundary.
REQ-023 GrantA SHALL equal (state==SHOW_A) and GrantB SHALL equal (state==SHOW_B), registered.
REQ-024 DigitEn_n and Seg_n SHALL be registered and SHALL reflect a new index or new data one cycle after the ScanTick that caused it.
REQ-025 In IDLE, DigitEn_n SHALL be 4'b1111 and Seg_n SHALL be 7'h7F.
REQ-026 Otherwise, DigitEn_n SHALL have exactly one zero, at the current index.
REQ-027 Seg_n SHALL be the decode of the display nibble at the current index: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
REQ-028 Nibbles 10-15 SHALL display blank (7'h7F).
REQ-029 With LZ_BLANK=1, a zero digit SHALL display blank when it and all higher digits are zero; digit 0 SHALL always display.

Reset
REQ-030 While Resetn=0 at a rising edge, the next state SHALL be: IDLE, index 0, hold counter 0, pending 0, shadow and display registers 0, GrantA=0, GrantB=0, DigitEn_n=4'b1111, Seg_n=7'h7F.
REQ-031 Reset asserted mid-frame or mid-hold SHALL abandon the operation with no residual pending request.
REQ-032 After release, the FSM SHALL remain in IDLE until the first frame boundary.

Verification
REQ-033 Reset then ReqA=1, DataA=16'h0042 -> after first boundary GrantA=1; scan shows digit0 Seg_n=7'h24, digit1 7'h19, digits 2-3 7'h7F.
REQ-034 In SHOW_A, pulse ReqB with DataB=16'h1234 mid-frame -> display unchanged until boundary, then GrantB=1, GrantA=0, digits 3..0 show 1,2,3,4 for exactly HOLD_FRAMES frames, then GrantA=1.
REQ-035 In SHOW_B, pulse ReqB with DataB=16'h0007 in the frame where the counter reaches 0 -> remains SHOW_B, shows 7, and the counter is reloaded to HOLD_FRAMES-1.
REQ-036 HOLD_FRAMES=2, ReqA=0, one ReqB -> IDLE after 2 frames, with DigitEn_n=4'b1111.
REQ-037 Assert Resetn=0 for one cycle during SHOW_B -> all REQ-030 values on the next edge, and no SHOW_B re-entry without a new ReqB.
REQ-038 DataA=16'h00AF with LZ_BLANK=0 -> all four digits enabled in turn; digits 0-1 show blank, digits 2-3 show 7'h40.

Source files
------------

// File: rtl/seg_scan_arbiter.sv
// Two-source arbiter for a 4-digit multiplexed 7-segment display: B (key echo) pre-empts A (score) for HOLD_FRAMES frames.
// Latency: outputs registered, 1 cycle after ScanTick; no backpressure, state changes only at frame boundaries.
module seg_scan_arbiter #(
    parameter int HOLD_FRAMES = 250,
    parameter int LZ_BLANK    = 1
) (
    input  logic        Clk,
    input  logic        Resetn,
    input  logic        ScanTick,
    input  logic        ReqA,
    input  logic [15:0] DataA,
    input  logic        ReqB,
    input  logic [15:0] DataB,
    output logic        GrantA,
    output logic        GrantB,
    output logic [3:0]  DigitEn_n,
    output logic [6:0]  Seg_n
);

    localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_FRAMES - 1);

    typedef enum logic [1:0] {IDLE, SHOW_A, SHOW_B} state_t;

    state_t        state, state_nxt;
    logic [1:0]    idx, idx_nxt;
    logic [HW-1:0] hold, hold_nxt;
    logic          pending, pending_nxt;
    logic [15:0]   shadow, shadow_nxt;
    logic [15:0]   disp, disp_nxt;
    logic          boundary, pend_eff;
    logic [15:0]   shadow_eff;
    logic [3:0]    nib;
    logic          lz;
    logic [3:0]    en_nxt;
    logic [6:0]    seg_nxt;

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // A ReqB in the boundary cycle itself still wins that boundary.
    always_comb begin
        boundary    = ScanTick && (idx == 2'd3);
        pend_eff    = pending | ReqB;
        shadow_eff  = ReqB ? DataB : shadow;
        state_nxt   = state;
        idx_nxt     = ScanTick ? idx + 2'd1 : idx;
        hold_nxt    = hold;
        pending_nxt = pend_eff;
        shadow_nxt  = shadow_eff;
        disp_nxt    = disp;
        if (boundary) begin
            if (pend_eff) begin
                state_nxt   = SHOW_B;
                hold_nxt    = HOLD_LOAD;
                pending_nxt = 1'b0;
                disp_nxt    = shadow_eff;
            end else begin
                case (state)
                    IDLE: begin
                        if (ReqA) begin
                            state_nxt = SHOW_A;
                            disp_nxt  = DataA;
                        end
                    end
                    SHOW_A: begin
                        if (ReqA) disp_nxt = DataA;
                        else      state_nxt = IDLE;
                    end
                    SHOW_B: begin
                        if (hold == '0) begin
                            if (ReqA) begin
                                state_nxt = SHOW_A;
                                disp_nxt  = DataA;
                            end else begin
                                state_nxt = IDLE;
                            end
                        end else begin
                            hold_nxt = hold - 1'b1;
                        end
                    end
                    default: state_nxt = IDLE;
                endcase
            end
        end
    end

    // Output decode works on next-state values so the pins follow the tick by exactly one cycle.
    always_comb begin
        nib = disp_nxt[{idx_nxt, 2'b00} +: 4];
        case (idx_nxt)
            2'd3:    lz = (disp_nxt[15:12] == 4'd0);
            2'd2:    lz = (disp_nxt[15:8] == 8'd0);
            2'd1:    lz = (disp_nxt[15:4] == 12'd0);
            default: lz = 1'b0;
        endcase
        seg_nxt = ((LZ_BLANK != 0) && lz) ? 7'h7F : decode(nib);
        en_nxt  = ~(4'b0001 << idx_nxt);
        if (state_nxt == IDLE) begin
            seg_nxt = 7'h7F;
            en_nxt  = 4'b1111;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            state     <= IDLE;
            idx       <= 2'd0;
            hold      <= '0;
            pending   <= 1'b0;
            shadow    <= 16'h0000;
            disp      <= 16'h0000;
            GrantA    <= 1'b0;
            GrantB    <= 1'b0;
            DigitEn_n <= 4'b1111;
            Seg_n     <= 7'h7F;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            hold      <= hold_nxt;
            pending   <= pending_nxt;
            shadow    <= shadow_nxt;
            disp      <= disp_nxt;
            GrantA    <= (state_nxt == SHOW_A);
            GrantB    <= (state_nxt == SHOW_B);
            DigitEn_n <= en_nxt;
            Seg_n     <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_arbiter.sv
// Directed bench: u1 uses default parameters, u2 uses HOLD_FRAMES=2 and LZ_BLANK=0; both share stimulus.
module tb_seg_scan_arbiter;

    logic        Clk = 1'b0;
    logic        Resetn, ScanTick, ReqA, ReqB;
    logic [15:0] DataA, DataB;
    logic        ga1, gb1, ga2, gb2;
    logic [3:0]  en1, en2;
    logic [6:0]  seg1, seg2;
    int          ncmp = 0;
    int          nfail = 0;

    always #5 Clk = ~Clk;

    seg_scan_arbiter u1 (
        .Clk(Clk), .Resetn(Resetn), .ScanTick(ScanTick), .ReqA(ReqA), .DataA(DataA),
        .ReqB(ReqB), .DataB(DataB), .GrantA(ga1), .GrantB(gb1), .DigitEn_n(en1), .Seg_n(seg1)
    );

    seg_scan_arbiter #(.HOLD_FRAMES(2), .LZ_BLANK(0)) u2 (
        .Clk(Clk), .Resetn(Resetn), .ScanTick(ScanTick), .ReqA(ReqA), .DataA(DataA),
        .ReqB(ReqB), .DataB(DataB), .GrantA(ga2), .GrantB(gb2), .DigitEn_n(en2), .Seg_n(seg2)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic out1(input string tag, input logic ga, input logic gb,
                        input logic [3:0] en, input logic [6:0] seg);
        chk({tag, ".u1.GrantA"}, 16'(ga1), 16'(ga));
        chk({tag, ".u1.GrantB"}, 16'(gb1), 16'(gb));
        chk({tag, ".u1.DigitEn_n"}, 16'(en1), 16'(en));
        chk({tag, ".u1.Seg_n"}, 16'(seg1), 16'(seg));
    endtask

    task automatic out2(input string tag, input logic ga, input logic gb,
                        input logic [3:0] en, input logic [6:0] seg);
        chk({tag, ".u2.GrantA"}, 16'(ga2), 16'(ga));
        chk({tag, ".u2.GrantB"}, 16'(gb2), 16'(gb));
        chk({tag, ".u2.DigitEn_n"}, 16'(en2), 16'(en));
        chk({tag, ".u2.Seg_n"}, 16'(seg2), 16'(seg));
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            ScanTick = 1'b1;
            cyc();
            ScanTick = 1'b0;
            cyc();
        end
    endtask

    task automatic pulse_b(input logic [15:0] d);
        ReqB  = 1'b1;
        DataB = d;
        cyc();
        ReqB  = 1'b0;
    endtask

    initial begin
        Resetn = 1'b0; ScanTick = 1'b0; ReqA = 1'b0; ReqB = 1'b0;
        DataA = 16'h0000; DataB = 16'h0000;
        cyc(); cyc();
        out1("reset", 1'b0, 1'b0, 4'b1111, 7'h7F);
        out2("reset", 1'b0, 1'b0, 4'b1111, 7'h7F);

        // Score 0042 shown after the first boundary, leading zeros blanked.
        Resetn = 1'b1; ReqA = 1'b1; DataA = 16'h0042;
        tick(1);
        out1("idle_until_boundary", 1'b0, 1'b0, 4'b1111, 7'h7F);
        tick(3);
        out1("a_d0", 1'b1, 1'b0, 4'b1110, 7'h24);
        tick(1);
        out1("a_d1", 1'b1, 1'b0, 4'b1101, 7'h19);
        tick(1);
        out1("a_d2", 1'b1, 1'b0, 4'b1011, 7'h7F);
        tick(1);
        out1("a_d3", 1'b1, 1'b0, 4'b0111, 7'h7F);

        // Mid-frame ReqB: no change until the boundary, then 1234 for 250 frames.
        tick(2);
        pulse_b(16'h1234);
        out1("b_pending_no_tear", 1'b1, 1'b0, 4'b1101, 7'h19);
        tick(3);
        out1("b_d0", 1'b0, 1'b1, 4'b1110, 7'h19);
        tick(1);
        out1("b_d1", 1'b0, 1'b1, 4'b1101, 7'h30);
        tick(1);
        out1("b_d2", 1'b0, 1'b1, 4'b1011, 7'h24);
        tick(1);
        out1("b_d3", 1'b0, 1'b1, 4'b0111, 7'h79);
        tick(1 + 248 * 4);
        out1("b_frame249", 1'b0, 1'b1, 4'b1110, 7'h19);
        tick(4);
        out1("b_expire_to_a", 1'b1, 1'b0, 4'b1110, 7'h24);

        // ReqB coinciding with the expiry boundary keeps SHOW_B and reloads the hold.
        pulse_b(16'h1234);
        tick(4);
        chk("b2_enter.u1.GrantB", 16'(gb1), 16'd1);
        tick(249 * 4);
        chk("b2_last_frame.u1.GrantB", 16'(gb1), 16'd1);
        tick(3);
        ScanTick = 1'b1; ReqB = 1'b1; DataB = 16'h0007;
        cyc();
        ScanTick = 1'b0; ReqB = 1'b0;
        cyc();
        out1("b_reload_d0", 1'b0, 1'b1, 4'b1110, 7'h78);
        tick(1);
        out1("b_reload_d1", 1'b0, 1'b1, 4'b1101, 7'h7F);
        tick(3 + 248 * 4);
        chk("b_reload_frame249.u1.GrantB", 16'(gb1), 16'd1);
        tick(4);
        out1("b_reload_expire", 1'b1, 1'b0, 4'b1110, 7'h24);

        // Reset during SHOW_B with a second ReqB pending.
        pulse_b(16'h1234);
        tick(4);
        chk("b3_enter.u1.GrantB", 16'(gb1), 16'd1);
        tick(1);
        pulse_b(16'h5678);
        ReqA = 1'b0; Resetn = 1'b0;
        cyc();
        out1("mid_hold_reset", 1'b0, 1'b0, 4'b1111, 7'h7F);
        Resetn = 1'b1;
        tick(8);
        out1("no_residual_pending", 1'b0, 1'b0, 4'b1111, 7'h7F);

        // 00AF with blanking off on u2; u1 blanks the zero digits.
        Resetn = 1'b0;
        cyc();
        Resetn = 1'b1; ReqA = 1'b1; DataA = 16'h00AF;
        tick(4);
        out2("lz0_d0", 1'b1, 1'b0, 4'b1110, 7'h7F);
        tick(1);
        out2("lz0_d1", 1'b1, 1'b0, 4'b1101, 7'h7F);
        tick(1);
        out2("lz0_d2", 1'b1, 1'b0, 4'b1011, 7'h40);
        chk("lz1_d2.u1.Seg_n", 16'(seg1), 16'h007F);
        tick(1);
        out2("lz0_d3", 1'b1, 1'b0, 4'b0111, 7'h40);

        // HOLD_FRAMES=2 with ReqA low: B for two frames, then IDLE.
        ReqA = 1'b0;
        tick(1);
        out2("a_drop_idle", 1'b0, 1'b0, 4'b1111, 7'h7F);
        pulse_b(16'h1234);
        tick(4);
        out2("h2_enter", 1'b0, 1'b1, 4'b1110, 7'h19);
        tick(4);
        out2("h2_frame1", 1'b0, 1'b1, 4'b1110, 7'h19);
        tick(4);
        out2("h2_idle", 1'b0, 1'b0, 4'b1111, 7'h7F);
        chk("h250_still_b.u1.GrantB", 16'(gb1), 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
